// File: rtl/mc_mi_sram.sv
// Burst responder for the cache core's mi_* protocol against a single-port
// synchronous memory with one-cycle read latency and a memory-side stall.
module mc_mi_sram #(
  parameter int ADDR_WIDTH     = 24,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     mi_addr,
  input  logic [6:0]                mi_len,
  input  logic                      mi_rw,
  input  logic                      mi_valid,
  output logic                      mi_ready,
  input  logic [31:0]               mi_wdata,
  output logic                      mi_wack,
  output logic                      mi_wlast,
  output logic [31:0]               mi_rdata,
  output logic                      mi_rstb,
  output logic                      mi_rlast,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_stall
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [6:0]            len_q, len_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_last_pend_q, rd_last_pend_d;

  logic [ADDR_WIDTH-1:0] addr_sum_s;
  logic                  is_last_s;
  logic                  unused_addr_s;

  // Sum is formed at full address width so bursts wrap at the top of memory.
  assign addr_sum_s    = base_q + ADDR_WIDTH'(cnt_q);
  assign is_last_s     = (cnt_q == len_q);
  assign unused_addr_s = ^addr_sum_s;

  assign mem_addr  = addr_sum_s[MEM_ADDR_WIDTH-1:0];
  assign mem_wdata = mi_wdata;
  assign mi_rdata  = mem_rdata;
  assign mi_rstb   = rd_pend_q;
  assign mi_rlast  = rd_pend_q & rd_last_pend_q;
  assign mi_ready  = (state_q == ST_IDLE) & ~rd_pend_q;

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    rd_pend_d      = 1'b0;
    rd_last_pend_d = 1'b0;
    mi_wack        = 1'b0;
    mi_wlast       = 1'b0;
    mem_we         = 1'b0;
    mem_re         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mi_valid && mi_ready) begin
          base_d  = mi_addr;
          len_d   = mi_len;
          cnt_d   = 7'd0;
          state_d = mi_rw ? ST_READ : ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (!mem_stall) begin
          mi_wack  = 1'b1;
          mem_we   = 1'b1;
          mi_wlast = is_last_s;
          cnt_d    = cnt_q + 7'd1;
          if (is_last_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_READ: begin
        // The strobe for an issued word appears one cycle later, with the data.
        if (!mem_stall) begin
          mem_re         = 1'b1;
          rd_pend_d      = 1'b1;
          rd_last_pend_d = is_last_s;
          cnt_d          = cnt_q + 7'd1;
          if (is_last_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and burst bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      base_q         <= '0;
      cnt_q          <= 7'd0;
      len_q          <= 7'd0;
      rd_pend_q      <= 1'b0;
      rd_last_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      rd_pend_q      <= rd_pend_d;
      rd_last_pend_q <= rd_last_pend_d;
    end
  end

endmodule

// File: tb/tb_mc_mi_sram.sv
// Self-checking bench for mc_mi_sram: a behavioural memory plus a per-burst
// schedule model derived from the stall pattern drives cycle-exact checks.
module tb_mc_mi_sram;
  localparam int AW = 24;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] mi_addr;
  logic [6:0]    mi_len;
  logic          mi_rw, mi_valid, mi_ready;
  logic [31:0]   mi_wdata, mi_rdata;
  logic          mi_wack, mi_wlast, mi_rstb, mi_rlast;
  logic [MW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_we, mem_re, mem_stall;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_arr [0:65535];
  logic [31:0] ref_mem [0:65535];
  logic [31:0] mem_rdata_r;

  mc_mi_sram #(.ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw), .mi_valid(mi_valid),
    .mi_ready(mi_ready), .mi_wdata(mi_wdata), .mi_wack(mi_wack),
    .mi_wlast(mi_wlast), .mi_rdata(mi_rdata), .mi_rstb(mi_rstb),
    .mi_rlast(mi_rlast), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata_r <= mem_arr[mem_addr];
  end
  assign mem_rdata = mem_rdata_r;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_strobes(input string tag);
    check_eq({tag, "_ready"}, {31'd0, mi_ready}, 32'd1);
    check_eq({tag, "_wack"},  {31'd0, mi_wack},  32'd0);
    check_eq({tag, "_wlast"}, {31'd0, mi_wlast}, 32'd0);
    check_eq({tag, "_rstb"},  {31'd0, mi_rstb},  32'd0);
    check_eq({tag, "_rlast"}, {31'd0, mi_rlast}, 32'd0);
    check_eq({tag, "_we"},    {31'd0, mem_we},   32'd0);
    check_eq({tag, "_re"},    {31'd0, mem_re},   32'd0);
  endtask

  // One burst: T cycle (accept) then every cycle until its final strobe.
  // During the burst either the next command is presented early (hold_next)
  // or random junk with random valid, all of which must be ignored.
  task automatic run_burst(input logic [AW-1:0] a, input int len, input bit rw,
                           input int stall_pct, input logic [31:0] stall_mask,
                           input bit hold_next, input logic [AW-1:0] n_a,
                           input int n_len, input bit n_rw);
    int          t [0:127];
    bit          stl [0:1023];
    logic [31:0] wd [0:127];
    int          c, p, prev_p, last_c;
    bit          iss, prev_iss;
    logic [AW-1:0] sum;

    stl[0] = 1'b0;
    for (int k = 1; k < 1024; k++)
      stl[k] = (k < 32 && stall_mask[k]) ||
               (k < 600 && int'($urandom_range(0, 99)) < stall_pct);
    // Word i is issued on the i-th unstalled cycle after acceptance.
    c = 0;
    for (int i = 0; i <= len; i++) begin
      c++;
      while (stl[c]) c++;
      t[i]  = c;
      wd[i] = $urandom;
    end
    last_c = t[len] + (rw ? 1 : 0);

    @(negedge clk);
    mi_valid  = 1'b1;
    mi_addr   = a;
    mi_len    = len[6:0];
    mi_rw     = rw;
    mem_stall = $urandom_range(0, 1);
    mi_wdata  = $urandom;
    #1;
    check_eq("ready_at_T", {31'd0, mi_ready}, 32'd1);

    p = 0;
    prev_p = 0;
    prev_iss = 1'b0;
    for (c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (hold_next) begin
        mi_valid = 1'b1;
        mi_addr  = n_a;
        mi_len   = n_len[6:0];
        mi_rw    = n_rw;
      end else begin
        mi_valid = $urandom_range(0, 1);
        mi_addr  = $urandom;
        mi_len   = $urandom;
        mi_rw    = $urandom_range(0, 1);
      end
      mem_stall = stl[c];
      iss       = (p <= len) ? (t[p] == c) : 1'b0;
      mi_wdata  = (!rw && p <= len) ? wd[p] : $urandom;
      #1;
      check_eq("ready_busy", {31'd0, mi_ready}, 32'd0);
      sum = a + AW'(p);
      if (!rw) begin
        check_eq("wack",  {31'd0, mi_wack},  {31'd0, iss});
        check_eq("we",    {31'd0, mem_we},   {31'd0, iss});
        check_eq("wlast", {31'd0, mi_wlast}, {31'd0, iss && p == len});
        check_eq("w_re",  {31'd0, mem_re},   32'd0);
        check_eq("w_rstb", {31'd0, mi_rstb}, 32'd0);
        if (iss) begin
          check_eq("waddr", {16'd0, mem_addr}, {16'd0, sum[MW-1:0]});
          check_eq("wdata", mem_wdata, wd[p]);
          ref_mem[sum[MW-1:0]] = wd[p];
        end
      end else begin
        check_eq("re",     {31'd0, mem_re},  {31'd0, iss});
        check_eq("r_wack", {31'd0, mi_wack}, 32'd0);
        check_eq("r_we",   {31'd0, mem_we},  32'd0);
        if (iss) check_eq("raddr", {16'd0, mem_addr}, {16'd0, sum[MW-1:0]});
        check_eq("rstb",  {31'd0, mi_rstb},  {31'd0, prev_iss});
        check_eq("rlast", {31'd0, mi_rlast}, {31'd0, prev_iss && prev_p == len});
        if (prev_iss) begin
          sum = a + AW'(prev_p);
          check_eq("rdata", mi_rdata, ref_mem[sum[MW-1:0]]);
        end
      end
      prev_iss = iss;
      prev_p   = p;
      if (iss) p++;
    end
  endtask

  initial begin
    logic [AW-1:0] cur_a, nxt_a;
    int            cur_len, nxt_len;
    bit            cur_rw, nxt_rw, hold;

    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] <= 32'(i);
      ref_mem[i] = 32'(i);
    end
    rst_n = 1'b0; mi_valid = 1'b0; mi_addr = '0; mi_len = 7'd0; mi_rw = 1'b0;
    mi_wdata = 32'd0; mem_stall = 1'b0;
    #1;
    check_idle_strobes("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("ready_after_rst", {31'd0, mi_ready}, 32'd1);

    // Directed cases: plain write, pattern read, stall, wrap, single word.
    run_burst(24'h000100, 15, 1'b0, 0, 32'd0, 1'b0, '0, 0, 1'b0);
    run_burst(24'h000200, 15, 1'b1, 0, 32'd0, 1'b0, '0, 0, 1'b0);
    run_burst(24'h000400, 3,  1'b0, 0, 32'h4, 1'b0, '0, 0, 1'b0);
    run_burst(24'hFFFFFE, 3,  1'b1, 0, 32'd0, 1'b0, '0, 0, 1'b0);
    run_burst(24'h000500, 0,  1'b0, 0, 32'd0, 1'b0, '0, 0, 1'b0);
    // Write with a read held valid throughout, then that read.
    run_burst(24'h000600, 7,  1'b0, 20, 32'd0, 1'b1, 24'h000600, 7, 1'b1);
    run_burst(24'h000600, 7,  1'b1, 20, 32'd0, 1'b0, '0, 0, 1'b0);

    // Reset in the middle of a 16-word read after five strobes.
    @(negedge clk);
    mi_valid = 1'b1; mi_addr = 24'h000300; mi_len = 7'd15; mi_rw = 1'b1;
    mem_stall = 1'b0;
    #1;
    check_eq("rst_rd_ready_T", {31'd0, mi_ready}, 32'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      mi_valid = 1'b0;
      #1;
      check_eq("rst_rd_rstb", {31'd0, mi_rstb}, {31'd0, c >= 2});
      check_eq("rst_rd_rlast", {31'd0, mi_rlast}, 32'd0);
      if (c >= 2) check_eq("rst_rd_rdata", mi_rdata, ref_mem[16'h0300 + 16'(c - 2)]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_strobes("midrst");
    @(negedge clk);
    #1;
    check_idle_strobes("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle_strobes("midrst_rel");
    @(negedge clk);
    #1;
    check_idle_strobes("midrst_post");
    run_burst(24'h000700, 15, 1'b1, 0, 32'd0, 1'b0, '0, 0, 1'b0);

    // Randomized bursts with random stalls and early next commands.
    cur_a = $urandom; cur_len = $urandom_range(0, 127); cur_rw = $urandom_range(0, 1);
    for (int n = 0; n < 24; n++) begin
      nxt_a   = (n % 3 == 0) ? cur_a : AW'($urandom);
      nxt_len = $urandom_range(0, 127);
      nxt_rw  = $urandom_range(0, 1);
      hold    = $urandom_range(0, 1);
      run_burst(cur_a, cur_len, cur_rw, 25, 32'd0, hold, nxt_a, nxt_len, nxt_rw);
      cur_a = nxt_a; cur_len = nxt_len; cur_rw = nxt_rw;
    end

    @(negedge clk);
    mi_valid = 1'b0;
    #1;
    check_idle_strobes("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
